// File: rtl/commit_checker_pkg.sv
// Shared types for the commit checker: golden/core commit records, failure codes and FSM states.
package commit_checker_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REC_W  = 1 + IDX_W + DATA_W;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_PC  = 1'b1;

  typedef struct packed {
    logic              kind;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } commit_rec_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_UNDERRUN = 2'd2,
    FC_EXTRA    = 2'd3
  } fail_code_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_e;

  function automatic commit_rec_t reg_event(logic [IDX_W-1:0] idx, logic [DATA_W-1:0] data);
    commit_rec_t r;
    r.kind = KIND_REG;
    r.idx  = idx;
    r.data = data;
    return r;
  endfunction

  // PC redirects carry no register index; it is reported as zero.
  function automatic commit_rec_t pc_event(logic [DATA_W-1:0] data);
    commit_rec_t r;
    r.kind = KIND_PC;
    r.idx  = '0;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/commit_checker_if.sv
// Golden-record port, core commit events and checker status, bundled for the commit checker.
interface commit_checker_if;
  import commit_checker_pkg::*;

  logic                exp_valid;
  logic                exp_ready;
  logic                exp_kind;
  logic [IDX_W-1:0]    exp_idx;
  logic [DATA_W-1:0]   exp_data;
  logic                exp_last;

  logic                rdv;
  logic [IDX_W-1:0]    rd_m;
  logic [DATA_W-1:0]   rd_data;
  logic                pcv;
  logic [DATA_W-1:0]   pc_x;

  logic                done;
  logic                fail;
  logic [1:0]          fail_code;
  logic [REC_W-1:0]    fail_exp;
  logic [REC_W-1:0]    fail_got;
  logic [31:0]         match_count;

  modport master (
    output exp_valid, exp_kind, exp_idx, exp_data, exp_last,
    output rdv, rd_m, rd_data, pcv, pc_x,
    input  exp_ready, done, fail, fail_code, fail_exp, fail_got, match_count
  );

  modport slave (
    input  exp_valid, exp_kind, exp_idx, exp_data, exp_last,
    input  rdv, rd_m, rd_data, pcv, pc_x,
    output exp_ready, done, fail, fail_code, fail_exp, fail_got, match_count
  );
endinterface

// File: rtl/commit_checker_fifo.sv
// Golden-record FIFO: one push port, peek at head and head+1, pop 0..2 entries per cycle.
module commit_fifo
  import commit_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  commit_rec_t                  push_rec_i,
  input  logic                         push_last_i,
  input  logic [1:0]                   pop_i,
  output commit_rec_t                  head_o,
  output logic                         head_last_o,
  output commit_rec_t                  next_o,
  output logic                         next_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  commit_rec_t        rec_q  [DEPTH];
  logic [DEPTH-1:0]   last_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_nx;
  logic [CNT_W-1:0]   count_q;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
      count_q  <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      rec_q[wr_ptr_q]  <= push_rec_i;
      last_q[wr_ptr_q] <= push_last_i;
    end
  end

  assign rd_ptr_nx   = rd_ptr_q + PTR_W'(1);
  assign head_o      = rec_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];
  assign next_o      = rec_q[rd_ptr_nx];
  assign next_last_o = last_q[rd_ptr_nx];
  assign count_o     = count_q;

endmodule

// File: rtl/commit_checker.sv
// Compares M-stage commit events against buffered golden records and latches the first failure.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  commit_checker_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  chk_state_e        state_q, state_d;
  logic              exp_ready_q;
  logic              done_q;
  logic              fail_q;
  fail_code_e        fail_code_q, fail_code_d;
  commit_rec_t       fail_exp_q, fail_exp_d;
  commit_rec_t       fail_got_q, fail_got_d;
  logic [31:0]       match_count_q, match_count_d;

  logic              push;
  commit_rec_t       push_rec;
  logic [1:0]        pop;
  logic [1:0]        need;
  logic              err;
  commit_rec_t       head, next;
  logic              head_last, next_last;
  logic [CNT_W-1:0]  count, count_d;
  commit_rec_t       ev_reg, ev_pc, ev_first, pc_ref;

  assign push     = bus.exp_valid && exp_ready_q;
  assign push_rec = '{kind: bus.exp_kind, idx: bus.exp_idx, data: bus.exp_data};

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_rec_i  (push_rec),
    .push_last_i (bus.exp_last),
    .pop_i       (pop),
    .head_o      (head),
    .head_last_o (head_last),
    .next_o      (next),
    .next_last_o (next_last),
    .count_o     (count)
  );

  // Compare in trace print order: register write first, then PC redirect.
  always_comb begin
    need          = {1'b0, bus.rdv} + {1'b0, bus.pcv};
    ev_reg        = reg_event(bus.rd_m, bus.rd_data);
    ev_pc         = pc_event(bus.pc_x);
    ev_first      = bus.rdv ? ev_reg : ev_pc;
    pc_ref        = bus.rdv ? next : head;
    pop           = 2'd0;
    err           = 1'b0;
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    fail_exp_d    = fail_exp_q;
    fail_got_d    = fail_got_q;
    match_count_d = match_count_q;

    case (state_q)
      ST_RUN: begin
        if (need != 2'd0) begin
          if (count < CNT_W'(need)) begin
            err         = 1'b1;
            fail_code_d = FC_UNDERRUN;
            fail_exp_d  = '0;
            fail_got_d  = ev_first;
          end else if (bus.rdv && (head != ev_reg)) begin
            err         = 1'b1;
            fail_code_d = FC_MISMATCH;
            fail_exp_d  = head;
            fail_got_d  = ev_reg;
          end else if (bus.rdv && bus.pcv && head_last) begin
            err         = 1'b1;
            fail_code_d = FC_EXTRA;
            fail_exp_d  = '0;
            fail_got_d  = ev_pc;
          end else if (bus.pcv && ((pc_ref.kind != KIND_PC) || (pc_ref.data != bus.pc_x))) begin
            err         = 1'b1;
            fail_code_d = FC_MISMATCH;
            fail_exp_d  = pc_ref;
            fail_got_d  = ev_pc;
          end else begin
            pop           = need;
            match_count_d = match_count_q + 32'(need);
            if ((bus.rdv && bus.pcv) ? next_last : head_last) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (need != 2'd0) begin
          err         = 1'b1;
          fail_code_d = FC_EXTRA;
          fail_exp_d  = '0;
          fail_got_d  = ev_first;
        end
      end
      default: ;
    endcase

    if (err) state_d = ST_FAIL;
    count_d = count + CNT_W'(push) - CNT_W'(pop);
  end

  // FSM state and all status outputs, registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      exp_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_code_q   <= FC_NONE;
      fail_exp_q    <= '0;
      fail_got_q    <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      exp_ready_q   <= (state_d == ST_RUN) && (count_d < CNT_W'(DEPTH));
      done_q        <= (state_d == ST_DONE);
      fail_q        <= (state_d == ST_FAIL);
      fail_code_q   <= fail_code_d;
      fail_exp_q    <= fail_exp_d;
      fail_got_q    <= fail_got_d;
      match_count_q <= match_count_d;
    end
  end

  assign bus.exp_ready   = exp_ready_q;
  assign bus.done        = done_q;
  assign bus.fail        = fail_q;
  assign bus.fail_code   = fail_code_q;
  assign bus.fail_exp    = fail_exp_q;
  assign bus.fail_got    = fail_got_q;
  assign bus.match_count = match_count_q;

endmodule

// File: tb/tb_commit_checker.sv
// Scoreboard bench for commit_checker: directed trace scenarios plus randomized record/commit streams.
module tb_commit_checker;
  import commit_checker_pkg::*;

  localparam int DEPTH  = 8;
  localparam int M_RUN  = 0;
  localparam int M_DONE = 1;
  localparam int M_FAIL = 2;

  typedef struct packed {
    logic        last;
    commit_rec_t r;
  } grec_t;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        fail;
    logic [1:0]  code;
    logic [37:0] fexp;
    logic [37:0] fgot;
    logic [31:0] mc;
  } obs_t;

  logic clk;
  logic reset;
  commit_checker_if bus ();

  commit_checker #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: golden records as a plain queue, status as plain variables.
  grec_t       gq[$];
  int          m_st;
  logic [1:0]  m_code;
  commit_rec_t m_fexp, m_fgot;
  logic [31:0] m_mc;
  obs_t        sb[$];

  function automatic commit_rec_t mk_reg(logic [4:0] i, logic [31:0] d);
    commit_rec_t r; r.kind = 1'b0; r.idx = i; r.data = d; return r;
  endfunction
  function automatic commit_rec_t mk_pc(logic [31:0] d);
    commit_rec_t r; r.kind = 1'b1; r.idx = 5'd0; r.data = d; return r;
  endfunction
  function automatic grec_t mk_g(logic k, logic [4:0] i, logic [31:0] d, logic l);
    grec_t g; g.last = l; g.r.kind = k; g.r.idx = i; g.r.data = d; return g;
  endfunction
  function automatic logic model_ready();
    return (m_st == M_RUN) && (gq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    gq.delete(); m_st = M_RUN; m_code = 2'd0; m_fexp = '0; m_fgot = '0; m_mc = '0;
  endtask

  task automatic set_fail(input logic [1:0] c, input commit_rec_t e, input commit_rec_t g);
    m_st = M_FAIL; m_code = c; m_fexp = e; m_fgot = g;
  endtask

  task automatic model_step(input logic v, input grec_t g, input logic rv, input logic [4:0] ri,
                            input logic [31:0] rd, input logic pv, input logic [31:0] px);
    logic acc; int need; int k; logic lst;
    commit_rec_t er, ep, e0;
    acc  = v && model_ready();
    need = int'(rv) + int'(pv);
    er = mk_reg(ri, rd); ep = mk_pc(px); e0 = rv ? er : ep;
    k  = rv ? 1 : 0;
    if (m_st == M_DONE && need > 0) set_fail(2'd3, '0, e0);
    else if (m_st == M_RUN && need > 0) begin
      if (gq.size() < need) set_fail(2'd2, '0, e0);
      else if (rv && gq[0].r != er) set_fail(2'd1, gq[0].r, er);
      else if (rv && pv && gq[0].last) set_fail(2'd3, '0, ep);
      else if (pv && (gq[k].r.kind != 1'b1 || gq[k].r.data != px)) set_fail(2'd1, gq[k].r, ep);
      else begin
        lst = gq[need-1].last;
        repeat (need) void'(gq.pop_front());
        m_mc += 32'(need);
        if (lst) m_st = M_DONE;
      end
    end
    if (acc) gq.push_back(g);
  endtask

  task automatic drive_idle();
    bus.exp_valid = 0; bus.exp_kind = 0; bus.exp_idx = '0; bus.exp_data = '0; bus.exp_last = 0;
    bus.rdv = 0; bus.rd_m = '0; bus.rd_data = '0; bus.pcv = 0; bus.pc_x = '0;
  endtask

  // One clock of stimulus; the expected post-edge status goes to the scoreboard.
  task automatic cyc(input logic v, input grec_t g, input logic rv, input logic [4:0] ri,
                     input logic [31:0] rd, input logic pv, input logic [31:0] px);
    obs_t e;
    @(negedge clk); #1;
    bus.exp_valid = v; bus.exp_kind = g.r.kind; bus.exp_idx = g.r.idx;
    bus.exp_data = g.r.data; bus.exp_last = g.last;
    bus.rdv = rv; bus.rd_m = ri; bus.rd_data = rd; bus.pcv = pv; bus.pc_x = px;
    model_step(v, g, rv, ri, rd, pv, px);
    e.ready = model_ready(); e.done = (m_st == M_DONE); e.fail = (m_st == M_FAIL);
    e.code = m_code; e.fexp = m_fexp; e.fgot = m_fgot; e.mc = m_mc;
    sb.push_back(e);
  endtask

  task automatic push_rec(input logic k, input logic [4:0] i, input logic [31:0] d, input logic l);
    cyc(1'b1, mk_g(k, i, d, l), 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Scoreboard monitor: one expected entry per clocked stimulus cycle.
  always @(negedge clk) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.ready = bus.exp_ready; a.done = bus.done; a.fail = bus.fail; a.code = bus.fail_code;
      a.fexp = bus.fail_exp; a.fgot = bus.fail_got; a.mc = bus.match_count;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL status @%0t: got rdy=%b done=%b fail=%b code=%0d exp=%h got=%h mc=%0d ; want rdy=%b done=%b fail=%b code=%0d exp=%h got=%h mc=%0d",
                 $time, a.ready, a.done, a.fail, a.code, a.fexp, a.fgot, a.mc,
                 e.ready, e.done, e.fail, e.code, e.fexp, e.fgot, e.mc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic settle();
    @(negedge clk); #2;
    drive_idle();
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk); #2;
    drive_idle();
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.exp_ready), 64'd1);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_fail",  64'(bus.fail), 64'd0);
    chk("rst_code",  64'(bus.fail_code), 64'd0);
    chk("rst_fexp",  64'(bus.fail_exp), 64'd0);
    chk("rst_fgot",  64'(bus.fail_got), 64'd0);
    chk("rst_mc",    64'(bus.match_count), 64'd0);
    model_reset();
    @(negedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic run_random();
    grec_t recs[$];
    grec_t g;
    int n, ptr, post, sel;
    logic v, acc, rv, pv;
    logic [4:0] ri;
    logic [31:0] rd, px;
    for (int ep = 0; ep < 30; ep++) begin
      n = 3 + int'($urandom % 16);
      recs.delete();
      for (int i = 0; i < n; i++)
        recs.push_back(mk_g(($urandom % 10) < 3, 5'($urandom), $urandom, i == n - 1));
      ptr = 0; post = 0;
      for (int c = 0; c < 90 && post < 4; c++) begin
        v   = (ptr < n) && (($urandom % 10) < 7);
        g   = (ptr < n) ? recs[ptr] : '0;
        acc = v && model_ready();
        rv = 0; pv = 0; ri = '0; rd = '0; px = '0;
        sel = int'($urandom % 100);
        if (m_st == M_RUN) begin
          if (sel < 45 && gq.size() > 0) begin
            if (gq[0].r.kind == 1'b0) begin
              rv = 1; ri = gq[0].r.idx; rd = gq[0].r.data;
              if (gq.size() > 1 && gq[1].r.kind == 1'b1 && $urandom % 2 == 1) begin
                pv = 1; px = gq[1].r.data;
              end
            end else begin
              pv = 1; px = gq[0].r.data;
            end
          end else if (sel < 47) begin
            rv = 1'($urandom); pv = !rv || 1'($urandom);
            ri = 5'($urandom); rd = $urandom; px = $urandom;
          end
        end else if (m_st == M_DONE && sel < 20) begin
          rv = 1; ri = 5'($urandom); rd = $urandom;
        end
        if (rv && ($urandom % 40) == 0) rd = rd ^ (32'd1 << ($urandom % 32));
        if (pv && ($urandom % 40) == 0) px = px ^ (32'd1 << ($urandom % 32));
        cyc(v, g, rv, ri, rd, pv, px);
        if (acc) ptr++;
        if (m_st != M_RUN) post++;
      end
      do_reset();
    end
  endtask

  initial begin
    grec_t none;
    none = '0;
    drive_idle();
    reset = 1'b1;
    model_reset();
    do_reset();

    // Register write and PC redirect matched in one cycle, then an extra event after done.
    push_rec(1'b0, 5'd5, 32'h10, 1'b0);
    push_rec(1'b1, 5'd0, 32'h200, 1'b1);
    cyc(1'b0, none, 1'b1, 5'd5, 32'h10, 1'b1, 32'h200);
    settle();
    chk("t1_mc",   64'(bus.match_count), 64'd2);
    chk("t1_done", 64'(bus.done), 64'd1);
    chk("t1_fail", 64'(bus.fail), 64'd0);
    cyc(1'b0, none, 1'b1, 5'd1, 32'h1, 1'b0, 32'd0);
    settle();
    chk("t5_code", 64'(bus.fail_code), 64'd3);
    chk("t5_done", 64'(bus.done), 64'd0);
    do_reset();

    // Data mismatch on a register write.
    push_rec(1'b0, 5'd3, 32'hA, 1'b0);
    cyc(1'b0, none, 1'b1, 5'd3, 32'hB, 1'b0, 32'd0);
    settle();
    chk("t2_code", 64'(bus.fail_code), 64'd1);
    chk("t2_fexp", 64'(bus.fail_exp), {26'd0, 1'b0, 5'd3, 32'hA});
    chk("t2_fgot", 64'(bus.fail_got), {26'd0, 1'b0, 5'd3, 32'hB});
    chk("t2_mc",   64'(bus.match_count), 64'd0);
    do_reset();

    // Redirect with nothing buffered.
    cyc(1'b0, none, 1'b0, 5'd0, 32'd0, 1'b1, 32'h40);
    settle();
    chk("t3_code",  64'(bus.fail_code), 64'd2);
    chk("t3_ready", 64'(bus.exp_ready), 64'd0);
    do_reset();

    // Fill to DEPTH, free two slots in one cycle, then run ten records across the wrap.
    for (int i = 0; i < 8; i++)
      push_rec(1'(i % 2), 5'(i), 32'h100 + 32'(i), 1'b0);
    cyc(1'b1, mk_g(1'b0, 5'd8, 32'h108, 1'b0), 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    settle();
    chk("t4_full", 64'(bus.exp_ready), 64'd0);
    cyc(1'b1, mk_g(1'b0, 5'd8, 32'h108, 1'b0), 1'b1, 5'd0, 32'h100, 1'b1, 32'h101);
    settle();
    chk("t4_free", 64'(bus.exp_ready), 64'd1);
    push_rec(1'b0, 5'd8, 32'h108, 1'b0);
    push_rec(1'b1, 5'd9, 32'h109, 1'b1);
    for (int p = 1; p < 5; p++)
      cyc(1'b0, none, 1'b1, 5'(2 * p), 32'h100 + 32'(2 * p), 1'b1, 32'h101 + 32'(2 * p));
    settle();
    chk("t4_mc",   64'(bus.match_count), 64'd10);
    chk("t4_done", 64'(bus.done), 64'd1);
    do_reset();

    // Last record consumed by the write while a redirect arrives in the same cycle.
    push_rec(1'b0, 5'd7, 32'h77, 1'b1);
    push_rec(1'b1, 5'd0, 32'h300, 1'b0);
    cyc(1'b0, none, 1'b1, 5'd7, 32'h77, 1'b1, 32'h300);
    settle();
    chk("t7_code", 64'(bus.fail_code), 64'd3);
    do_reset();

    // Reset with four buffered records and a latched failure.
    for (int i = 0; i < 4; i++)
      push_rec(1'b0, 5'(i + 1), 32'h50 + 32'(i), 1'b0);
    cyc(1'b0, none, 1'b1, 5'd1, 32'hDEAD, 1'b0, 32'd0);
    settle();
    chk("t6_fail", 64'(bus.fail), 64'd1);
    do_reset();

    run_random();
    settle();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
